// File: rtl/bsg_manycore_npa_to_eva_pkg.sv
// rtl/bsg_manycore_npa_to_eva_pkg.sv - EVA layout types and field widths for NPA-to-EVA translation
package bsg_manycore_npa_to_eva_pkg;

  // Field widths of the vanilla-core EVA formats.
  localparam int max_global_x_cord_width_gp       = 6;
  localparam int max_global_y_cord_width_gp       = 6;
  localparam int global_epa_word_addr_width_gp    = 16;
  localparam int max_x_cord_width_gp              = 6;
  localparam int max_y_cord_width_gp              = 6;
  localparam int tile_group_epa_word_addr_width_gp = 15;
  localparam int host_dram_addr_width_gp          = 28;

  typedef enum logic [1:0] {
    e_eva_global     = 2'd0,
    e_eva_tile_group = 2'd1,
    e_eva_dram       = 2'd2,
    e_eva_host_dram  = 2'd3
  } eva_type_e;

  typedef struct packed {
    logic [1:0]                                  remote;
    logic [max_global_y_cord_width_gp-1:0]       y_cord;
    logic [max_global_x_cord_width_gp-1:0]       x_cord;
    logic [global_epa_word_addr_width_gp-1:0]    addr;
    logic [1:0]                                  low_bits;
  } bsg_manycore_global_addr_s;

  typedef struct packed {
    logic [2:0]                                  remote;
    logic [max_y_cord_width_gp-1:0]              y_cord;
    logic [max_x_cord_width_gp-1:0]              x_cord;
    logic [tile_group_epa_word_addr_width_gp-1:0] addr;
    logic [1:0]                                  low_bits;
  } bsg_manycore_tile_group_addr_s;

  typedef struct packed {
    logic [1:0]                                  is_host;
    logic [host_dram_addr_width_gp-1:0]          addr;
    logic [1:0]                                  low_bits;
  } bsg_manycore_host_dram_addr_s;

  // True when a zero-extended value has no set bits at or above the given width.
  function automatic logic fits_width(input logic [31:0] value, input int width);
    return (value >> width) == 32'd0;
  endfunction

endpackage

// File: rtl/bsg_dff_en.sv
// rtl/bsg_dff_en.sv - enabled register without reset for pipeline payload
module bsg_dff_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  // Payload only updates when the stage loads a new entry.
  always_ff @(posedge clk_i) begin
    if (en_i) data_o <= data_i;
  end

endmodule

// File: rtl/bsg_dff_reset_en.sv
// rtl/bsg_dff_reset_en.sv - enabled register with synchronous active-high reset
module bsg_dff_reset_en #(
  parameter int width_p     = 1,
  parameter int reset_val_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  // Reset wins over enable so in-flight entries are dropped immediately.
  always_ff @(posedge clk_i) begin
    if (reset_i)   data_o <= width_p'(reset_val_p);
    else if (en_i) data_o <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_npa_classify.sv
// rtl/bsg_manycore_npa_classify.sv - combinational NPA address-space classification
module bsg_manycore_npa_classify
  import bsg_manycore_npa_to_eva_pkg::*;
#(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int num_tiles_y_p  = 4
) (
  input  logic [x_cord_width_p-1:0] x_cord_i,
  input  logic [y_cord_width_p-1:0] y_cord_i,
  input  logic                      epa_msb_i,
  input  logic [x_cord_width_p-1:0] tgo_x_i,
  input  logic [y_cord_width_p-1:0] tgo_y_i,
  input  logic [x_cord_width_p-1:0] tg_dim_x_i,
  input  logic [y_cord_width_p-1:0] tg_dim_y_i,
  input  logic                      dram_enable_i,
  output eva_type_e                 eva_type_o,
  output logic [x_cord_width_p-1:0] rel_x_o,
  output logic [y_cord_width_p-1:0] rel_y_o
);

  logic is_host, is_dram, in_tile_group;

  // Coordinates relative to the tile-group origin; a wrap lands far outside the group.
  assign rel_x_o = x_cord_i - tgo_x_i;
  assign rel_y_o = y_cord_i - tgo_y_i;

  assign is_host = ~dram_enable_i
                 & (y_cord_i == y_cord_width_p'(1))
                 & (x_cord_i == '0)
                 & epa_msb_i;

  // Top and bottom rows hold the vcaches.
  assign is_dram = (y_cord_i == '0)
                 | (y_cord_i == y_cord_width_p'(num_tiles_y_p + 1));

  assign in_tile_group = (rel_x_o < tg_dim_x_i) & (rel_y_o < tg_dim_y_i);

  // Host space outranks DRAM, which outranks the local tile group.
  always_comb begin
    eva_type_o = e_eva_global;
    if (is_host)            eva_type_o = e_eva_host_dram;
    else if (is_dram)       eva_type_o = e_eva_dram;
    else if (in_tile_group) eva_type_o = e_eva_tile_group;
  end

endmodule

// File: rtl/bsg_manycore_npa_to_eva.sv
// rtl/bsg_manycore_npa_to_eva.sv - two-stage NPA (x,y,EPA) to vanilla-core EVA translator
module bsg_manycore_npa_to_eva
  import bsg_manycore_npa_to_eva_pkg::*;
#(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 28,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int num_tiles_y_p  = 4,
  parameter int vcache_size_p  = 1024,
  parameter int tag_width_p    = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic [x_cord_width_p-1:0] x_cord_i,
  input  logic [y_cord_width_p-1:0] y_cord_i,
  input  logic [addr_width_p-1:0]   epa_i,
  input  logic [tag_width_p-1:0]    tag_i,
  input  logic [x_cord_width_p-1:0] tgo_x_i,
  input  logic [y_cord_width_p-1:0] tgo_y_i,
  input  logic [x_cord_width_p-1:0] tg_dim_x_i,
  input  logic [y_cord_width_p-1:0] tg_dim_y_i,
  input  logic                      dram_enable_i,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [data_width_p-1:0]   eva_o,
  output logic [1:0]                eva_type_o,
  output logic [tag_width_p-1:0]    tag_o,
  output logic                      is_invalid_o
);

  localparam int lg_vcache_size_lp = $clog2(vcache_size_p);
  localparam int s1_width_lp = 3*x_cord_width_p + 3*y_cord_width_p + addr_width_p + tag_width_p + 1;
  localparam int s2_width_lp = 2 + 2*x_cord_width_p + 2*y_cord_width_p + addr_width_p + tag_width_p + 1;

  logic s1_v, s2_v, s2_en;

  // Stage 1: raw request plus the configuration snapshot taken at acceptance.
  logic [s1_width_lp-1:0]    s1_data;
  logic [x_cord_width_p-1:0] s1_x, s1_tgo_x, s1_dim_x;
  logic [y_cord_width_p-1:0] s1_y, s1_tgo_y, s1_dim_y;
  logic [addr_width_p-1:0]   s1_epa;
  logic [tag_width_p-1:0]    s1_tag;
  logic                      s1_dram_en;

  // Classification result computed on stage-1 contents.
  eva_type_e                 s1_type;
  logic [x_cord_width_p-1:0] s1_rel_x;
  logic [y_cord_width_p-1:0] s1_rel_y;

  // Stage 2: classified request awaiting EVA formation and consumption.
  logic [s2_width_lp-1:0]    s2_data;
  logic [1:0]                s2_type;
  logic [x_cord_width_p-1:0] s2_x, s2_rel_x;
  logic [y_cord_width_p-1:0] s2_y, s2_rel_y;
  logic [addr_width_p-1:0]   s2_epa;
  logic [tag_width_p-1:0]    s2_tag;
  logic                      s2_dram_en;

  // Stage 2 can load when empty or being drained; stage 1 can load when empty or moving on.
  assign s2_en   = ~s2_v | yumi_i;
  assign ready_o = ~s2_v | yumi_i | ~s1_v;

  bsg_dff_reset_en #(.width_p(1)) s1_v_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (ready_o),
    .data_i  (v_i),
    .data_o  (s1_v)
  );

  bsg_dff_en #(.width_p(s1_width_lp)) s1_payload_reg (
    .clk_i  (clk_i),
    .en_i   (ready_o & v_i),
    .data_i ({x_cord_i, y_cord_i, epa_i, tag_i, tgo_x_i, tgo_y_i,
              tg_dim_x_i, tg_dim_y_i, dram_enable_i}),
    .data_o (s1_data)
  );

  assign {s1_x, s1_y, s1_epa, s1_tag, s1_tgo_x, s1_tgo_y,
          s1_dim_x, s1_dim_y, s1_dram_en} = s1_data;

  bsg_manycore_npa_classify #(
    .x_cord_width_p (x_cord_width_p),
    .y_cord_width_p (y_cord_width_p),
    .num_tiles_y_p  (num_tiles_y_p)
  ) classify (
    .x_cord_i      (s1_x),
    .y_cord_i      (s1_y),
    .epa_msb_i     (s1_epa[addr_width_p-1]),
    .tgo_x_i       (s1_tgo_x),
    .tgo_y_i       (s1_tgo_y),
    .tg_dim_x_i    (s1_dim_x),
    .tg_dim_y_i    (s1_dim_y),
    .dram_enable_i (s1_dram_en),
    .eva_type_o    (s1_type),
    .rel_x_o       (s1_rel_x),
    .rel_y_o       (s1_rel_y)
  );

  bsg_dff_reset_en #(.width_p(1)) s2_v_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (s2_en),
    .data_i  (s1_v),
    .data_o  (s2_v)
  );

  bsg_dff_en #(.width_p(s2_width_lp)) s2_payload_reg (
    .clk_i  (clk_i),
    .en_i   (s2_en & s1_v),
    .data_i ({s1_type, s1_x, s1_y, s1_rel_x, s1_rel_y, s1_epa, s1_tag, s1_dram_en}),
    .data_o (s2_data)
  );

  assign {s2_type, s2_x, s2_y, s2_rel_x, s2_rel_y, s2_epa, s2_tag, s2_dram_en} = s2_data;

  // Zero-extended operands so every format is built with the same 32-bit arithmetic.
  logic [31:0] x_ext, y_ext, rel_x_ext, rel_y_ext, epa_ext, epa_no_msb;
  assign x_ext      = 32'(s2_x);
  assign y_ext      = 32'(s2_y);
  assign rel_x_ext  = 32'(s2_rel_x);
  assign rel_y_ext  = 32'(s2_rel_y);
  assign epa_ext    = 32'(s2_epa);
  assign epa_no_msb = epa_ext & ((32'd1 << (addr_width_p - 1)) - 32'd1);

  bsg_manycore_global_addr_s     global_addr;
  bsg_manycore_tile_group_addr_s tg_addr;
  bsg_manycore_host_dram_addr_s  host_addr;
  logic [31:0]                   eva_raw;
  logic                          invalid;

  // Stage 2: build the EVA for the class chosen in stage 1, or flag it unrepresentable.
  always_comb begin
    global_addr = '0;
    tg_addr     = '0;
    host_addr   = '0;
    eva_raw     = '0;
    invalid     = 1'b0;
    unique case (eva_type_e'(s2_type))
      e_eva_host_dram: begin
        host_addr.is_host = 2'b11;
        host_addr.addr    = epa_no_msb[host_dram_addr_width_gp-1:0];
        eva_raw           = host_addr;
      end
      e_eva_dram: begin
        // The striped hash used with DRAM mode enabled cannot be undone here.
        if (s2_dram_en || !fits_width(epa_ext, lg_vcache_size_lp)) begin
          invalid = 1'b1;
        end else begin
          eva_raw = 32'h8000_0000
                  | (32'(s2_y != '0) << (2 + lg_vcache_size_lp + x_cord_width_p))
                  | (x_ext << (2 + lg_vcache_size_lp))
                  | (epa_ext << 2);
        end
      end
      e_eva_tile_group: begin
        if (!fits_width(rel_x_ext, max_x_cord_width_gp)
            || !fits_width(rel_y_ext, max_y_cord_width_gp)
            || !fits_width(epa_ext, tile_group_epa_word_addr_width_gp)) begin
          invalid = 1'b1;
        end else begin
          tg_addr.remote = 3'b001;
          tg_addr.y_cord = rel_y_ext[max_y_cord_width_gp-1:0];
          tg_addr.x_cord = rel_x_ext[max_x_cord_width_gp-1:0];
          tg_addr.addr   = epa_ext[tile_group_epa_word_addr_width_gp-1:0];
          eva_raw        = tg_addr;
        end
      end
      e_eva_global: begin
        if (!fits_width(x_ext, max_global_x_cord_width_gp)
            || !fits_width(y_ext, max_global_y_cord_width_gp)
            || !fits_width(epa_ext, global_epa_word_addr_width_gp)) begin
          invalid = 1'b1;
        end else begin
          global_addr.remote = 2'b01;
          global_addr.y_cord = y_ext[max_global_y_cord_width_gp-1:0];
          global_addr.x_cord = x_ext[max_global_x_cord_width_gp-1:0];
          global_addr.addr   = epa_ext[global_epa_word_addr_width_gp-1:0];
          eva_raw            = global_addr;
        end
      end
    endcase
  end

  // Outputs read as zero whenever no result is presented, including right after reset.
  assign v_o          = s2_v;
  assign eva_o        = (s2_v & ~invalid) ? data_width_p'(eva_raw) : '0;
  assign eva_type_o   = s2_v ? s2_type : 2'b00;
  assign tag_o        = s2_v ? s2_tag : '0;
  assign is_invalid_o = s2_v & invalid;

  // A consumer may only take a result while one is being presented.
  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(yumi_i && !v_o));
  end

endmodule

// File: tb/tb_bsg_manycore_npa_to_eva.sv
// tb/tb_bsg_manycore_npa_to_eva.sv - scoreboard bench for the NPA-to-EVA translator
module tb_bsg_manycore_npa_to_eva;

  localparam int XW = 4, YW = 4, AW = 28, NTY = 4, VCS = 1024, TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, v_i, ready_o, dram_enable_i, v_o, yumi_i, is_invalid_o;
  logic [XW-1:0] x_cord_i, tgo_x_i, tg_dim_x_i;
  logic [YW-1:0] y_cord_i, tgo_y_i, tg_dim_y_i;
  logic [AW-1:0] epa_i;
  logic [TW-1:0] tag_i, tag_o;
  logic [31:0]   eva_o;
  logic [1:0]    eva_type_o;

  bsg_manycore_npa_to_eva #(
    .data_width_p(32), .addr_width_p(AW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .num_tiles_y_p(NTY), .vcache_size_p(VCS), .tag_width_p(TW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .x_cord_i(x_cord_i), .y_cord_i(y_cord_i), .epa_i(epa_i), .tag_i(tag_i),
    .tgo_x_i(tgo_x_i), .tgo_y_i(tgo_y_i), .tg_dim_x_i(tg_dim_x_i), .tg_dim_y_i(tg_dim_y_i),
    .dram_enable_i(dram_enable_i), .v_o(v_o), .yumi_i(yumi_i), .eva_o(eva_o),
    .eva_type_o(eva_type_o), .tag_o(tag_o), .is_invalid_o(is_invalid_o)
  );

  typedef struct {
    logic [31:0] eva;
    logic [1:0]  typ;
    logic [3:0]  tag;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_fail = 0;
  int   yumi_mode = 1;   // 0 random, 1 always take, 2 never take
  bit   mon_en = 0;
  int   tag_ctr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: EVA formats written as plain arithmetic on field positions.
  function automatic exp_t model(input int x, input int y, input longint epa, input int tx,
                                 input int ty, input int dx, input int dy, input bit den,
                                 input int tag);
    exp_t   e;
    longint v = 0;
    int     rx, ry;
    e.tag = tag[3:0];
    e.inv = 1'b0;
    rx = (x - tx + 16) % 16;
    ry = (y - ty + 16) % 16;
    if (!den && y == 1 && x == 0 && epa >= 64'h800_0000) begin
      e.typ = 2'd3;
      v = 64'hC000_0000 + (epa - 64'h800_0000) * 4;
    end else if (y == 0 || y == NTY + 1) begin
      e.typ = 2'd2;
      if (den || epa >= VCS) e.inv = 1'b1;
      else v = 64'h8000_0000 + ((y != 0) ? 64'h1_0000 : 0) + x * 64'h1000 + epa * 4;
    end else if (rx < dx && ry < dy) begin
      e.typ = 2'd1;
      if (epa >= 64'h8000) e.inv = 1'b1;
      else v = 64'h2000_0000 + ry * 64'h80_0000 + rx * 64'h2_0000 + epa * 4;
    end else begin
      e.typ = 2'd0;
      if (epa >= 64'h1_0000) e.inv = 1'b1;
      else v = 64'h4000_0000 + y * 64'h100_0000 + x * 64'h4_0000 + epa * 4;
    end
    e.eva = e.inv ? 32'h0 : v[31:0];
    return e;
  endfunction

  // Monitor: compares presented results with the scoreboard head and drives yumi.
  exp_t prev;
  bit   prev_hold = 0;
  always @(negedge clk) begin
    if (mon_en) begin : mon
      int occ;
      bit take;
      occ  = sb.size();
      take = 1'b0;
      if (reset_i) begin
        prev_hold = 1'b0;
        yumi_i    = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("hold_v_o", 32'(v_o), 32'd1);
          chk("hold_eva", eva_o, prev.eva);
          chk("hold_type", 32'(eva_type_o), 32'(prev.typ));
          chk("hold_tag", 32'(tag_o), 32'(prev.tag));
          chk("hold_inv", 32'(is_invalid_o), 32'(prev.inv));
        end
        if (v_o) begin
          if (occ == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: got v_o=1 tag=%0d required no result", tag_o);
          end else begin
            chk("eva", eva_o, sb[0].eva);
            chk("eva_type", 32'(eva_type_o), 32'(sb[0].typ));
            chk("tag", 32'(tag_o), 32'(sb[0].tag));
            chk("is_invalid", 32'(is_invalid_o), 32'(sb[0].inv));
          end
          case (yumi_mode)
            0:       take = ($urandom_range(0, 3) != 0);
            1:       take = 1'b1;
            default: take = 1'b0;
          endcase
          if (take && occ > 0) void'(sb.pop_front());
        end
        yumi_i    = take;
        prev_hold = v_o && !take;
        prev.eva  = eva_o;
        prev.typ  = eva_type_o;
        prev.tag  = tag_o;
        prev.inv  = is_invalid_o;
        #1;
        chk("ready_o", 32'(ready_o), (occ == 2 && !take) ? 32'd0 : 32'd1);
      end
    end
  end

  // Present one request from negedge+2 until accepted; returns at a later negedge+2.
  task automatic issue(input int x, input int y, input longint epa, input int tx, input int ty,
                       input int dx, input int dy, input bit den);
    int waited = 0;
    bit done = 0;
    v_i = 1'b1;
    x_cord_i = XW'(x);  y_cord_i = YW'(y);  epa_i = AW'(epa);
    tgo_x_i = XW'(tx);  tgo_y_i = YW'(ty);
    tg_dim_x_i = XW'(dx);  tg_dim_y_i = YW'(dy);
    dram_enable_i = den;
    tag_i = TW'(tag_ctr);
    while (!done) begin
      #1;
      if (ready_o) begin
        sb.push_back(model(x, y, epa, tx, ty, dx, dy, den, tag_ctr));
        tag_ctr = (tag_ctr + 1) % 16;
        done = 1;
      end else if (waited >= 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_timeout: ready_o low for %0d cycles required accept", waited);
        done = 1;
      end
      @(negedge clk);
      #2;
      waited++;
    end
    v_i = 1'b0;
  endtask

  // Idle cycles with scrambled inputs so late configuration changes are exercised.
  task automatic idle(input int n);
    v_i = 1'b0;
    repeat (n) begin
      x_cord_i = XW'($urandom);  y_cord_i = YW'($urandom);  epa_i = AW'($urandom);
      tgo_x_i = XW'($urandom);   tgo_y_i = YW'($urandom);
      tg_dim_x_i = XW'($urandom); tg_dim_y_i = YW'($urandom);
      dram_enable_i = 1'($urandom);
      @(negedge clk);
      #2;
    end
  endtask

  task automatic issue_random();
    int     x, y, sel;
    longint epa;
    x   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
    sel = $urandom_range(0, 3);
    if (sel == 0)      y = 0;
    else if (sel == 1) y = 1;
    else if (sel == 2) y = NTY + 1;
    else               y = $urandom_range(0, 15);
    sel = $urandom_range(0, 3);
    if (sel == 0)      epa = $urandom_range(0, 1023);
    else if (sel == 1) epa = $urandom_range(0, 65535);
    else if (sel == 2) epa = $urandom & 32'h0FFF_FFFF;
    else               epa = 32'h0800_0000 | ($urandom & 32'h07FF_FFFF);
    issue(x, y, epa, $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 3) == 0));
  endtask

  initial begin
    reset_i = 1'b1;  v_i = 1'b0;  yumi_i = 1'b0;
    x_cord_i = '0;  y_cord_i = '0;  epa_i = '0;  tag_i = '0;
    tgo_x_i = '0;  tgo_y_i = '0;  tg_dim_x_i = '0;  tg_dim_y_i = '0;  dram_enable_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_v_o", 32'(v_o), 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    chk("rst_eva", eva_o, 32'd0);
    chk("rst_type", 32'(eva_type_o), 32'd0);
    chk("rst_tag", 32'(tag_o), 32'd0);
    chk("rst_inv", 32'(is_invalid_o), 32'd0);
    reset_i = 1'b0;
    #2;
    mon_en = 1'b1;
    idle(2);

    // Latency on an empty pipe: result appears one cycle after the stage-1 capture.
    yumi_mode = 1;
    issue(3, 2, 'h10, 8, 8, 1, 1, 1'b0);
    chk("latency_n1_v_o", 32'(v_o), 32'd0);
    @(negedge clk);
    #2;
    chk("latency_n2_v_o", 32'(v_o), 32'd1);
    idle(3);

    // Directed classes and boundaries.
    issue(2, 3, 'h4, 1, 1, 4, 4, 1'b0);
    issue(1, 2, 'h7FFF, 14, 0, 4, 4, 1'b0);
    issue(1, 2, 'h8000, 14, 0, 4, 4, 1'b0);
    issue(5, NTY + 1, 'h3, 0, 0, 0, 0, 1'b0);
    issue(5, NTY + 1, 'h400, 0, 0, 0, 0, 1'b0);
    issue(7, 0, 'h3FF, 0, 0, 0, 0, 1'b0);
    issue(7, 0, 'h5, 0, 0, 0, 0, 1'b1);
    issue(0, 1, 'h800_0123, 0, 0, 0, 0, 1'b0);
    issue(0, 1, 'h800_0123, 0, 0, 0, 0, 1'b1);
    issue(0, 1, 'h7FF_FFFF, 0, 0, 0, 0, 1'b0);
    issue(15, 15, 'hFFFF, 0, 0, 0, 0, 1'b0);
    issue(15, 15, 'h1_0000, 0, 0, 0, 0, 1'b0);
    idle(4);

    // Eight back-to-back requests with the consumer stalled for three cycles mid-stream.
    fork
      begin
        repeat (8) issue_random();
      end
      begin
        repeat (3) @(negedge clk);
        yumi_mode = 2;
        repeat (3) @(negedge clk);
        yumi_mode = 1;
      end
    join
    idle(4);

    // Randomized traffic with random consumer backpressure.
    yumi_mode = 0;
    repeat (600) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else issue_random();
    end
    yumi_mode = 1;
    idle(6);

    // Reset with two requests in flight drops both.
    yumi_mode = 2;
    issue(3, 2, 'h10, 8, 8, 1, 1, 1'b0);
    issue(2, 3, 'h4, 1, 1, 4, 4, 1'b0);
    reset_i = 1'b1;
    sb.delete();
    @(negedge clk);
    #2;
    chk("flush_v_o", 32'(v_o), 32'd0);
    chk("flush_ready_o", 32'(ready_o), 32'd1);
    reset_i = 1'b0;
    yumi_mode = 1;
    idle(5);

    yumi_mode = 0;
    repeat (100) issue_random();

    // Drain with a bounded wait.
    yumi_mode = 1;
    begin : drain
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(negedge clk);
        #2;
        n++;
      end
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
